// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//   Generic pipeline stage register with a valid/ready handshake and a
//   2-entry skid buffer (main register M drives the outputs, skid register S
//   catches the one entry that arrives while M is stalled). in_ready is
//   taken from a register, so out_ready never reaches in_ready
//   combinationally. A flush empties both entries. With BUBBLE_ZERO=1 the
//   data outputs read as 0 (NOP) whenever out_valid is low.
//
//   Optional feature macro: PIPE_STAGE_PERF_CNT_EN
//     defined   -> saturating stall_cnt / flush_cnt performance counters
//     undefined -> both counter ports are tied to 0
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   synchronous reset, active-high
//   in_valid   in   upstream offers an entry
//   in_ready   out  stage can accept (registered)
//   in_pc4     in   PC+4 of the offered entry        [PC_W]
//   in_inst    in   instruction word                 [INST_W]
//   in_side    in   sideband control bits            [SIDE_W]
//   out_valid  out  output entry valid
//   out_ready  in   downstream accepts (0 = stall)
//   out_pc4    out  PC+4 of the output entry         [PC_W]
//   out_inst   out  instruction of the output entry  [INST_W]
//   out_side   out  sideband of the output entry     [SIDE_W]
//   flush      in   discard all buffered entries
//   stall_cnt  out  cycles with out_valid=1, out_ready=0   [CNT_W]
//   flush_cnt  out  flush cycles that discarded an entry   [CNT_W]
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int PC_W        = 32,
  parameter int INST_W      = 32,
  parameter int SIDE_W      = 8,
  parameter int BUBBLE_ZERO = 1,
  parameter int CNT_W       = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc4,
  input  logic [INST_W-1:0] in_inst,
  input  logic [SIDE_W-1:0] in_side,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc4,
  output logic [INST_W-1:0] out_inst,
  output logic [SIDE_W-1:0] out_side,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int ENT_W = PC_W + INST_W + SIDE_W;

  logic [ENT_W-1:0] in_data;
  logic [ENT_W-1:0] m_data_q, m_data_d;
  logic [ENT_W-1:0] s_data_q, s_data_d;
  logic             m_valid_q, m_valid_d;
  logic             s_valid_q, s_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             in_fire;
  logic             out_fire;
  logic             m_free;

  assign in_data  = {in_pc4, in_inst, in_side};
  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = m_valid_q & out_ready;
  // M can be (re)loaded this edge: it is empty or its entry leaves now.
  assign m_free   = ~m_valid_q | out_fire;

  always_comb begin
    m_data_d  = m_data_q;
    s_data_d  = s_data_q;
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    if (flush) begin
      m_data_d  = '0;
      s_data_d  = '0;
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (m_free) begin
      if (s_valid_q) begin
        // in_ready was low this cycle, so no new entry competes with S.
        m_data_d  = s_data_q;
        m_valid_d = 1'b1;
        s_valid_d = 1'b0;
      end else if (in_fire) begin
        m_data_d  = in_data;
        m_valid_d = 1'b1;
      end else begin
        // Data is kept so BUBBLE_ZERO=0 still shows the last entry.
        m_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      s_data_d  = in_data;
      s_valid_d = 1'b1;
    end
    // Ready for the next cycle is decided from next-state only.
    in_ready_d = ~s_valid_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      m_data_q   <= '0;
      s_data_q   <= '0;
      m_valid_q  <= 1'b0;
      s_valid_q  <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      m_data_q   <= m_data_d;
      s_data_q   <= s_data_d;
      m_valid_q  <= m_valid_d;
      s_valid_q  <= s_valid_d;
      in_ready_q <= in_ready_d;
    end
  end

  logic [ENT_W-1:0] out_data;

  always_comb begin
    out_data = m_data_q;
    if ((BUBBLE_ZERO != 0) && !m_valid_q) out_data = '0;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = m_valid_q;
  assign out_pc4   = out_data[ENT_W-1 -: PC_W];
  assign out_inst  = out_data[SIDE_W +: INST_W];
  assign out_side  = out_data[SIDE_W-1:0];

`ifdef PIPE_STAGE_PERF_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + 1'b1;
  endfunction

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (m_valid_q && !out_ready) stall_cnt_d = sat_inc(stall_cnt_q);
    if (flush && (m_valid_q || s_valid_q)) flush_cnt_d = sat_inc(flush_cnt_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_pc4;
  logic [31:0] in_inst;
  logic [7:0]  in_side;
  logic        out_ready;
  logic        flush;

  logic             in_ready_a, out_valid_a;
  logic [31:0]      out_pc4_a, out_inst_a;
  logic [7:0]       out_side_a;
  logic [CNT_W-1:0] stall_cnt_a, flush_cnt_a;

  logic             in_ready_b, out_valid_b;
  logic [31:0]      out_pc4_b, out_inst_b;
  logic [7:0]       out_side_b;
  logic [CNT_W-1:0] stall_cnt_b, flush_cnt_b;

  // Instance A: NOP bubbles; instance B: last data stays visible.
  pipe_stage_skid #(.PC_W(32), .INST_W(32), .SIDE_W(8), .BUBBLE_ZERO(1), .CNT_W(CNT_W)) dut_a (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_pc4(in_pc4), .in_inst(in_inst), .in_side(in_side),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_pc4(out_pc4_a), .out_inst(out_inst_a), .out_side(out_side_a),
    .flush(flush), .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a));

  pipe_stage_skid #(.PC_W(32), .INST_W(32), .SIDE_W(8), .BUBBLE_ZERO(0), .CNT_W(CNT_W)) dut_b (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_pc4(in_pc4), .in_inst(in_inst), .in_side(in_side),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_pc4(out_pc4_b), .out_inst(out_inst_b), .out_side(out_side_b),
    .flush(flush), .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cexp(input int v);
`ifdef PIPE_STAGE_PERF_CNT_EN
    return v;
`else
    return 0;
`endif
  endfunction

  // ---------------- behavioural model: bounded FIFO of depth 2 -------------
  logic [71:0] mq[$];
  logic [71:0] last_q;
  int          stall_m;
  int          flush_m;

  always @(posedge clock) begin
    bit infire;
    bit outfire;
    infire  = in_valid && (mq.size() < 2);
    outfire = (mq.size() > 0) && out_ready;
    if (reset) begin
      mq.delete();
      last_q  = '0;
      stall_m = 0;
      flush_m = 0;
    end else begin
      if (mq.size() > 0 && !out_ready && stall_m < CNT_MAX) stall_m++;
      if (flush && mq.size() > 0 && flush_m < CNT_MAX) flush_m++;
      if (flush) begin
        mq.delete();
        last_q = '0;
      end else begin
        if (outfire) void'(mq.pop_front());
        if (infire) mq.push_back({in_pc4, in_inst, in_side});
        if (mq.size() > 0) last_q = mq[0];
      end
    end
  end

  // ---------------- compare process ----------------------------------------
  always @(negedge clock) begin
    if (chk_en) begin
      logic [71:0] exp_a;
      logic [71:0] exp_b;
      exp_a = (mq.size() > 0) ? mq[0] : 72'd0;
      exp_b = (mq.size() > 0) ? mq[0] : last_q;
      chk("a.out_valid", {71'd0, out_valid_a}, {71'd0, mq.size() > 0});
      chk("a.in_ready",  {71'd0, in_ready_a},  {71'd0, mq.size() < 2});
      chk("a.out_data",  {out_pc4_a, out_inst_a, out_side_a}, exp_a);
      chk("b.out_valid", {71'd0, out_valid_b}, {71'd0, mq.size() > 0});
      chk("b.in_ready",  {71'd0, in_ready_b},  {71'd0, mq.size() < 2});
      chk("b.out_data",  {out_pc4_b, out_inst_b, out_side_b}, exp_b);
      chk("a.stall_cnt", 72'(stall_cnt_a), 72'(cexp(stall_m)));
      chk("a.flush_cnt", 72'(flush_cnt_a), 72'(cexp(flush_m)));
      chk("b.stall_cnt", 72'(stall_cnt_b), 72'(cexp(stall_m)));
      chk("b.flush_cnt", 72'(flush_cnt_b), 72'(cexp(flush_m)));
    end
  end

  // ---------------- stimulus -----------------------------------------------
  task automatic drv(input bit v, input logic [31:0] inst, input bit ordy,
                     input bit fl, input bit rs);
    in_valid  = v;
    in_inst   = inst;
    in_pc4    = inst + 32'h1000;
    in_side   = inst[7:0];
    out_ready = ordy;
    flush     = fl;
    reset     = rs;
  endtask

  task automatic tick;
    @(negedge clock);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    drv(0, 32'h0, 0, 0, 1);
    tick; tick;
    chk_en = 1'b1;
    chk("reset.out_valid", 72'(out_valid_a), 72'd0);
    chk("reset.out_inst",  72'(out_inst_a),  72'd0);
    chk("reset.in_ready",  72'(in_ready_a),  72'd1);
    chk("reset.stall_cnt", 72'(stall_cnt_a), 72'd0);
    chk("reset.flush_cnt", 72'(flush_cnt_a), 72'd0);

    // Stream of four entries, one cycle latency each.
    drv(1, 32'h11, 1, 0, 0); tick;
    chk("stream.0x11", 72'(out_inst_a), 72'h11);
    drv(1, 32'h22, 1, 0, 0); tick;
    chk("stream.0x22", 72'(out_inst_a), 72'h22);
    drv(1, 32'h33, 1, 0, 0); tick;
    chk("stream.0x33", 72'(out_inst_a), 72'h33);
    drv(1, 32'h44, 1, 0, 0); tick;
    chk("stream.0x44", 72'(out_inst_a), 72'h44);
    chk("stream.in_ready", 72'(in_ready_a), 72'd1);

    // Bubble with garbage on the input bus.
    drv(0, 32'hDEADBEEF, 1, 0, 0); tick;
    chk("bubble.a.out_valid", 72'(out_valid_a), 72'd0);
    chk("bubble.a.out_inst",  72'(out_inst_a),  72'd0);
    chk("bubble.b.out_inst",  72'(out_inst_b),  72'h44);

    // Stall and skid.
    drv(1, 32'h11, 1, 0, 0); tick;
    drv(1, 32'h22, 0, 0, 0); tick;
    chk("skid.hold", 72'(out_inst_a), 72'h11);
    chk("skid.in_ready", 72'(in_ready_a), 72'd0);
    chk("skid.stall_cnt", 72'(stall_cnt_a), 72'(cexp(1)));
    drv(0, 32'h0, 1, 0, 0); tick;
    chk("skid.drain", 72'(out_inst_a), 72'h22);
    chk("skid.in_ready_back", 72'(in_ready_a), 72'd1);
    tick;
    chk("skid.empty", 72'(out_valid_a), 72'd0);
    chk("skid.b.last", 72'(out_inst_b), 72'h22);

    // Flush with both entries full while 0x33 is offered.
    drv(1, 32'h11, 0, 0, 0); tick;
    drv(1, 32'h22, 0, 0, 0); tick;
    drv(1, 32'h33, 0, 1, 0); tick;
    chk("flush.out_valid", 72'(out_valid_a), 72'd0);
    chk("flush.out_inst",  72'(out_inst_a),  72'd0);
    chk("flush.b.out_inst", 72'(out_inst_b), 72'd0);
    chk("flush.in_ready",  72'(in_ready_a),  72'd1);
    chk("flush.flush_cnt", 72'(flush_cnt_a), 72'(cexp(1)));
    drv(0, 32'h0, 1, 0, 0); tick;
    chk("flush.no_0x33", 72'(out_valid_a), 72'd0);

    // Flush discards an in_fire of the same cycle; empty flush not counted.
    drv(1, 32'h11, 0, 0, 0); tick;
    drv(1, 32'h55, 0, 1, 0); tick;
    drv(0, 32'h0, 1, 0, 0); tick;
    chk("flush.no_0x55", 72'(out_valid_a), 72'd0);
    drv(0, 32'h0, 1, 1, 0); tick;
    chk("flush.cnt_two", 72'(flush_cnt_a), 72'(cexp(2)));
    chk("flush.stall_four", 72'(stall_cnt_a), 72'(cexp(4)));

    // Reset mid-operation, then reset together with flush.
    drv(1, 32'h11, 0, 0, 0); tick;
    drv(1, 32'h22, 0, 0, 0); tick;
    drv(1, 32'h66, 0, 0, 1); tick;
    chk("rst.out_valid", 72'(out_valid_a), 72'd0);
    chk("rst.b.out_inst", 72'(out_inst_b), 72'd0);
    chk("rst.in_ready",  72'(in_ready_a),  72'd1);
    chk("rst.stall_cnt", 72'(stall_cnt_a), 72'd0);
    drv(1, 32'h11, 0, 0, 0); tick;
    drv(1, 32'h22, 0, 0, 0); tick;
    drv(1, 32'h77, 0, 1, 1); tick;
    chk("rstfl.out_valid", 72'(out_valid_a), 72'd0);
    chk("rstfl.in_ready",  72'(in_ready_a),  72'd1);
    chk("rstfl.flush_cnt", 72'(flush_cnt_a), 72'd0);

    // Long stall saturates the 4-bit counter.
    drv(1, 32'h11, 0, 0, 0); tick;
    drv(0, 32'h0, 0, 0, 0);
    repeat (20) tick;
    chk("sat.stall_cnt", 72'(stall_cnt_a), 72'(cexp(15)));
    chk("sat.out_inst",  72'(out_inst_a),  72'h11);

    // Randomized traffic.
    drv(0, 32'h0, 1, 0, 1); tick;
    reset = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (in_valid && !in_ready_a) begin
        // Data must stay stable while offered and not accepted; valid may drop.
        in_valid = ($urandom_range(0, 9) != 0);
      end else begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_pc4   = $urandom;
        in_inst  = $urandom;
        in_side  = 8'($urandom_range(0, 255));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      reset     = ($urandom_range(0, 199) == 0);
      tick;
    end

    drv(0, 32'h0, 1, 0, 0);
    tick; tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor of the IF/ID pipeline register: a generic stage register between any two pipeline stages of the pipelined CPU.
- Replaces the write-enable/bubble pair with a valid/ready handshake and a 2-entry skid buffer, so a downstream stall does not need a combinational path back upstream.
- Adds a flush that clears all buffered entries, and forces NOP (zero) output on bubbles.
- Carries a PC+4 field, an instruction field and a generic sideband field.

Parameters:
- PC_W, 32, width of the PC+4 field.
- INST_W, 32, width of the instruction field.
- SIDE_W, 8, width of the sideband field (control bits carried alongside); minimum 1.
- BUBBLE_ZERO, 1: 1 forces output data to 0 while out_valid=0; 0 leaves the last data visible.
- CNT_W, 16, width of the performance counters.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous reset, active-high.
- in_valid  in  1  upstream offers an entry.
- in_ready  out  1  stage can accept; registered.
- in_pc4  in  PC_W  PC+4 of the offered instruction.
- in_inst  in  INST_W  instruction word.
- in_side  in  SIDE_W  sideband control.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts (0 = stall, e.g. load-use hazard).
- out_pc4  out  PC_W  PC+4 of the output entry.
- out_inst  out  INST_W  instruction of the output entry.
- out_side  out  SIDE_W  sideband of the output entry.
- flush  in  1  discard all entries (taken branch/jump).
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.
- flush_cnt  out  CNT_W  flush cycles that discarded at least one valid entry.

Behaviour:
- Storage: main register (M, drives outputs) and skid register (S), each with its own valid bit.
- Fire definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = ~S_valid, registered. No combinational path exists from out_ready to in_ready.
- Priority is reset > flush > normal operation.
- Reset: M_valid=0, S_valid=0, all data 0, in_ready=1, out_valid=0, outputs 0, counters 0.
- Flush:
  - Next edge gives M_valid=0, S_valid=0, data 0 and in_ready=1.
  - An in_fire in the same cycle is discarded.
  - out_fire in the same cycle still counts as consumed downstream.
- Normal operation, per edge:
  - M empty or out_fire, S valid: M<=S, S cleared. in_fire cannot occur because in_ready=0.
  - M empty or out_fire, S empty, in_fire: M<=input, M_valid=1.
  - M empty or out_fire, S empty, no in_fire: M_valid<=0.
  - M valid and no out_fire, in_fire: S<=input, S_valid=1, so in_ready=0 next cycle.
  - M valid and no out_fire, no in_fire: hold.
- Latency is 1 cycle from in_fire to out_valid when M is empty. Sustained throughput is 1 entry/cycle.
- Ordering is strict FIFO. No entry is duplicated or dropped except by flush.
- Outputs: out_valid=M_valid. If BUBBLE_ZERO=1 and M_valid=0, out_pc4, out_inst and out_side are 0 (NOP bubble).
- in_valid may drop without being accepted. Upstream must hold its data stable while in_valid=1 and in_ready=0.

Optional Feature:
- PIPE_STAGE_PERF_CNT_EN defined:
  - stall_cnt increments each cycle with out_valid=1 and out_ready=0.
  - flush_cnt increments each cycle flush=1 while M_valid or S_valid is 1.
  - Both counters saturate at all-ones and clear on reset.
- Macro undefined: counter logic is absent and both ports are tied to 0. Port list is unchanged.

Test Plan:
- Stream, PC_W=INST_W=32: in_valid=1, out_ready=1 for 4 cycles with inst 0x11,0x22,0x33,0x44.
  - out_inst is 0x11..0x44 on consecutive cycles, each 1 cycle after its input.
  - in_ready stays 1 throughout.
- Stall and skid: M holds 0x11, out_ready=0, in_fire 0x22.
  - S=0x22, in_ready=0 next cycle, out_inst holds 0x11.
  - Raise out_ready: outputs are 0x11 then 0x22, in_ready returns to 1.
- Flush with both entries full and in_valid=1 offering 0x33 in the flush cycle.
  - Next cycle out_valid=0, out_inst=0, in_ready=1.
  - 0x33 never appears at the output.
- Reset mid-operation: reset=1 while S valid and out_ready=0.
  - Next edge gives out_valid=0, all outputs 0, in_ready=1, counters 0.
  - Reset asserted together with flush behaves identically.
- Bubble: BUBBLE_ZERO=1 with in_valid=0 and in_inst=0xDEADBEEF gives out_inst=0. With BUBBLE_ZERO=0, out_inst retains the last valid value.
- Counters with PIPE_STAGE_PERF_CNT_EN, CNT_W=4:
  - Stall for 20 cycles: stall_cnt=15 (saturated).
  - Two flushes with data held, one flush while empty: flush_cnt=2.
  - Without the macro, both counters read 0.
